// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port sequencer for the shared instruction/data memory.
// Optional feature macro MEM_ARB_LOCK_EN adds lock0/lock1 to pin arbitration to the last winner.
module mem_arbiter #(
    parameter int WIDTH   = 32,
    parameter int MEM_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             we0,
    input  logic [WIDTH-1:0] adr0,
    input  logic [WIDTH-1:0] wd0,
    output logic             ready0,
    input  logic             req1,
    input  logic             we1,
    input  logic [WIDTH-1:0] adr1,
    input  logic [WIDTH-1:0] wd1,
    output logic             ready1,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_wd,
    output logic             mem_we,
    input  logic [WIDTH-1:0] mem_rd,
    output logic             busy,
    output logic             grant_id,
`ifdef MEM_ARB_LOCK_EN
    input  logic             lock0,
    input  logic             lock1,
`endif
    output logic [1:0]       state_o
);

    // Handshake: req/we/adr/wd are sampled only in IDLE; ready is a one-cycle
    // completion pulse, and a req still high in the following IDLE is a new request.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   adr_q, adr_d;
    logic [WIDTH-1:0]   wd_q, wd_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;
    logic               we_q, we_d;
    logic               mem_we_q, mem_we_d;
    logic               grant_q, grant_d;
    logic               last_q, last_d;

    logic               lock_active;
    logic               req_last;
    logic               win_valid;
    logic               win_port;

`ifdef MEM_ARB_LOCK_EN
    assign lock_active = last_q ? lock1 : lock0;
`else
    assign lock_active = 1'b0;
`endif
    assign req_last = last_q ? req1 : req0;

    // A held lock ignores the other port entirely, even when the locked port is idle.
    always_comb begin
        win_valid = 1'b0;
        win_port  = 1'b0;
        if (lock_active) begin
            win_valid = req_last;
            win_port  = last_q;
        end else if (req0 && req1) begin
            win_valid = 1'b1;
            win_port  = ~last_q;
        end else if (req0) begin
            win_valid = 1'b1;
            win_port  = 1'b0;
        end else if (req1) begin
            win_valid = 1'b1;
            win_port  = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        adr_d    = adr_q;
        wd_d     = wd_q;
        we_d     = we_q;
        mem_we_d = 1'b0;
        rdata_d  = rdata_q;
        grant_d  = grant_q;
        last_d   = last_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d  = ACCESS;
                    cnt_d    = CNT_INIT;
                    adr_d    = win_port ? adr1 : adr0;
                    wd_d     = win_port ? wd1 : wd0;
                    we_d     = win_port ? we1 : we0;
                    mem_we_d = win_port ? we1 : we0;
                    grant_d  = win_port;
                    last_d   = win_port;
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (!we_q) begin
                        rdata_d = mem_rd;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            adr_q    <= '0;
            wd_q     <= '0;
            we_q     <= 1'b0;
            mem_we_q <= 1'b0;
            rdata_q  <= '0;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            adr_q    <= adr_d;
            wd_q     <= wd_d;
            we_q     <= we_d;
            mem_we_q <= mem_we_d;
            rdata_q  <= rdata_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
        end
    end

    assign ready0   = (state_q == DONE) && !grant_q;
    assign ready1   = (state_q == DONE) && grant_q;
    assign busy     = (state_q != IDLE);
    assign rdata    = rdata_q;
    assign mem_adr  = adr_q;
    assign mem_wd   = wd_q;
    assign mem_we   = mem_we_q;
    assign grant_id = grant_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiters (MEM_LAT 1 and 3) share random stimulus and are checked
// every cycle against a transaction-timeline model; honours MEM_ARB_LOCK_EN when defined.
module tb_mem_arbiter;

    localparam int W     = 32;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, req0, we0, req1, we1;
    logic [W-1:0] adr0, wd0, adr1, wd1;
`ifdef MEM_ARB_LOCK_EN
    logic         lock0, lock1;
`endif

    logic [1:0]         ready0_w, ready1_w, mem_we_w, busy_w, grant_w;
    logic [1:0][W-1:0]  rdata_w, mem_adr_w, mem_wd_w, mem_rd_w;
    logic [1:0][1:0]    state_w;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory contents are a fixed function of address; 0x10 holds 0xDEADBEEF.
    function automatic logic [W-1:0] mem_fn(logic [W-1:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    assign mem_rd_w[0] = mem_fn(mem_adr_w[0]);
    assign mem_rd_w[1] = mem_fn(mem_adr_w[1]);

    mem_arbiter #(.WIDTH(W), .MEM_LAT(LAT_A)) u_dut_a (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .adr0(adr0), .wd0(wd0), .ready0(ready0_w[0]),
        .req1(req1), .we1(we1), .adr1(adr1), .wd1(wd1), .ready1(ready1_w[0]),
        .rdata(rdata_w[0]), .mem_adr(mem_adr_w[0]), .mem_wd(mem_wd_w[0]),
        .mem_we(mem_we_w[0]), .mem_rd(mem_rd_w[0]), .busy(busy_w[0]),
        .grant_id(grant_w[0]),
`ifdef MEM_ARB_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .state_o(state_w[0])
    );

    mem_arbiter #(.WIDTH(W), .MEM_LAT(LAT_B)) u_dut_b (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .adr0(adr0), .wd0(wd0), .ready0(ready0_w[1]),
        .req1(req1), .we1(we1), .adr1(adr1), .wd1(wd1), .ready1(ready1_w[1]),
        .rdata(rdata_w[1]), .mem_adr(mem_adr_w[1]), .mem_wd(mem_wd_w[1]),
        .mem_we(mem_we_w[1]), .mem_rd(mem_rd_w[1]), .busy(busy_w[1]),
        .grant_id(grant_w[1]),
`ifdef MEM_ARB_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .state_o(state_w[1])
    );

    // Reference model: el = cycles since grant (0 = idle, 1..LAT access, LAT+1 done).
    int           el[2];
    bit           tport[2], twe[2], gid[2], last_g[2];
    logic [W-1:0] m_adr[2], m_wd[2], m_rd[2];
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];

    function automatic int lat_of(int i);
        return (i == 0) ? LAT_A : LAT_B;
    endfunction

    function automatic logic [W-1:0] ext1(logic b);
        return {{(W-1){1'b0}}, b};
    endfunction

    function automatic string tg(int i, string n);
        return $sformatf("lat%0d.%s", lat_of(i), n);
    endfunction

    task automatic check_eq(string tag, logic [W-1:0] got, logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(int i);
        int  L;
        bit  lk, win_v, win_p;
        L = lat_of(i);
        if (reset) begin
            el[i] = 0; tport[i] = 0; twe[i] = 0; gid[i] = 0; last_g[i] = 1;
            m_adr[i] = '0; m_wd[i] = '0; m_rd[i] = '0;
            if (i == 0) exp_q0.delete(); else exp_q1.delete();
        end else if (el[i] == 0) begin
            lk = 0;
`ifdef MEM_ARB_LOCK_EN
            lk = last_g[i] ? lock1 : lock0;
`endif
            win_v = 0; win_p = 0;
            if (lk) begin
                win_p = last_g[i];
                win_v = win_p ? req1 : req0;
            end else if (req0 && req1) begin
                win_v = 1; win_p = !last_g[i];
            end else if (req0 || req1) begin
                win_v = 1; win_p = req1;
            end
            if (win_v) begin
                el[i] = 1;
                tport[i] = win_p;
                gid[i] = win_p;
                last_g[i] = win_p;
                twe[i] = win_p ? we1 : we0;
                m_adr[i] = win_p ? adr1 : adr0;
                m_wd[i] = win_p ? wd1 : wd0;
                if (!twe[i]) begin
                    if (i == 0) exp_q0.push_back(mem_fn(m_adr[i]));
                    else exp_q1.push_back(mem_fn(m_adr[i]));
                end
            end
        end else if (el[i] <= L) begin
            if (el[i] == L && !twe[i]) m_rd[i] = mem_fn(m_adr[i]);
            el[i]++;
        end else begin
            el[i] = 0;
        end
    endtask

    task automatic check_outputs(int i);
        int           L;
        bit           done;
        logic [1:0]   st;
        logic [W-1:0] e;
        L = lat_of(i);
        done = (el[i] == L + 1);
        st = (el[i] == 0) ? 2'd0 : ((el[i] <= L) ? 2'd1 : 2'd2);
        check_eq(tg(i, "busy"),     ext1(busy_w[i]),   ext1(el[i] != 0));
        check_eq(tg(i, "mem_we"),   ext1(mem_we_w[i]), ext1(el[i] == 1 && twe[i]));
        check_eq(tg(i, "ready0"),   ext1(ready0_w[i]), ext1(done && !tport[i]));
        check_eq(tg(i, "ready1"),   ext1(ready1_w[i]), ext1(done && tport[i]));
        check_eq(tg(i, "grant_id"), ext1(grant_w[i]),  ext1(gid[i]));
        check_eq(tg(i, "state"),    {{(W-2){1'b0}}, state_w[i]}, {{(W-2){1'b0}}, st});
        check_eq(tg(i, "mem_adr"),  mem_adr_w[i], m_adr[i]);
        check_eq(tg(i, "mem_wd"),   mem_wd_w[i],  m_wd[i]);
        check_eq(tg(i, "rdata"),    rdata_w[i],   m_rd[i]);
        if (done && !twe[i]) begin
            e = 'x;
            if (i == 0) begin
                if (exp_q0.size() > 0) e = exp_q0.pop_front();
            end else begin
                if (exp_q1.size() > 0) e = exp_q1.pop_front();
            end
            check_eq(tg(i, "rd_scoreboard"), rdata_w[i], e);
        end
    endtask

    // Inputs are already set (at a negedge); advance one clock and check both DUTs.
    task automatic cycle();
        model_step(0);
        model_step(1);
        @(posedge clk);
        @(negedge clk);
        check_outputs(0);
        check_outputs(1);
    endtask

    task automatic idle_in();
        reset = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    endtask

    task automatic cycles(int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        reset = 1; req0 = 0; we0 = 0; adr0 = '0; wd0 = '0;
        req1 = 0; we1 = 0; adr1 = '0; wd1 = '0;
`ifdef MEM_ARB_LOCK_EN
        lock0 = 0; lock1 = 0;
`endif
        cycles(2);

        // Port 0 read of 0x10
        idle_in(); req0 = 1; adr0 = 32'h10;
        cycle();
        req0 = 0;
        cycles(6);
        check_eq("lat1.read_deadbeef", rdata_w[0], 32'hDEADBEEF);
        check_eq("lat3.read_deadbeef", rdata_w[1], 32'hDEADBEEF);

        // Port 1 write; rdata must keep the previous read value
        req1 = 1; we1 = 1; adr1 = 32'h20; wd1 = 32'h12345678;
        cycle();
        req1 = 0; we1 = 0;
        cycles(6);
        check_eq("lat1.rdata_after_write", rdata_w[0], 32'hDEADBEEF);
        check_eq("lat3.rdata_after_write", rdata_w[1], 32'hDEADBEEF);

        // Both ports requesting continuously from reset
        reset = 1; cycle();
        idle_in(); req0 = 1; req1 = 1; adr0 = 32'h30; adr1 = 32'h40;
        cycles(16);

        // Reset during ACCESS of a port 1 write, then a tie
        reset = 1; cycle();
        idle_in(); req1 = 1; we1 = 1; adr1 = 32'h50; wd1 = 32'hCAFE0001;
        cycle();
        idle_in(); reset = 1;
        cycle();
        idle_in(); req0 = 1; req1 = 1;
        cycles(4);
        idle_in();
        cycles(6);

`ifdef MEM_ARB_LOCK_EN
        // Lock port 1 after it wins, then release
        reset = 1; cycle();
        idle_in(); req1 = 1; adr1 = 32'h60;
        cycle();
        req1 = 0; lock1 = 1;
        cycles(5);
        req0 = 1; req1 = 1;
        cycles(12);
        lock1 = 0;
        cycles(8);
        idle_in();
        cycles(6);
`endif

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            reset = ($urandom_range(0, 99) == 0);
            req0  = ($urandom_range(0, 9) < 6);
            req1  = ($urandom_range(0, 9) < 6);
            we0   = $urandom_range(0, 1);
            we1   = $urandom_range(0, 1);
            adr0  = W'($urandom_range(0, 7)) << 4;
            adr1  = W'($urandom_range(0, 7)) << 4;
            wd0   = $urandom;
            wd1   = $urandom;
`ifdef MEM_ARB_LOCK_EN
            if ($urandom_range(0, 9) == 0) lock0 = ~lock0;
            if ($urandom_range(0, 9) == 0) lock1 = ~lock1;
`endif
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
